// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES constants. Holds the FIPS-197 forward S-box as a
//             constant 256-entry table, plus sub_byte(), which looks up one
//             byte in it. SubBytes and key-expansion SubWord both use it.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Forward S-box, indexed by the byte value. The high nibble selects the
  // row (one line below) and the low nibble selects the column.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Value of the output register while in reset. It is deliberately not
  // S(00) = 63, so a reset output can be told apart from a real result.
  localparam logic [7:0] SBOX_RST_VAL = 8'h00;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox
//  Purpose  : Registered AES forward S-box. Each clock it passes one byte
//             through the fixed S-box table and registers the result, so the
//             latency is one cycle.
//  Ports    : clk       - rising-edge clock
//             rst_n     - asynchronous active-low reset (output forced to 00)
//             in_toSub  - byte to substitute, sampled on every rising edge
//             out_Subed - S(in_toSub) of the byte sampled on the previous edge
//  Revision : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_toSub,
  output logic [7:0] out_Subed
);

  logic [7:0] sub_d;
  logic [7:0] sub_q;

  always_comb begin
    sub_d = sub_byte(in_toSub);
  end

  // The register loads on every edge, because it has no enable. The output
  // comes only from the flop, so there is no path from input to output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= SBOX_RST_VAL;
    end else begin
      sub_q <= sub_d;
    end
  end

  assign out_Subed = sub_q;

endmodule : aes_sbox
`default_nettype wire

// File: tb/tb_aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_sbox
//  Purpose  : Self-checking bench for aes_sbox. The reference S-box is built
//             from its mathematical definition: the GF(2^8) multiplicative
//             inverse modulo x^8+x^4+x^3+x+1, followed by the affine
//             transform with constant 63.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_toSub;
  logic [7:0] out_Subed;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] ref_tbl [0:255];

  aes_sbox dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_toSub  (in_toSub),
    .out_Subed (out_Subed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  task automatic build_ref();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      ref_tbl[a] = affine(inv);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive v after a falling edge, then check the output just after the next
  // rising edge.
  task automatic step(input logic [7:0] v, input string tag);
    @(negedge clk);
    in_toSub = v;
    @(posedge clk);
    #1;
    check(tag, out_Subed, ref_tbl[v]);
  endtask

  logic [7:0] stream_in  [0:8];
  logic [7:0] stream_out [0:8];
  logic [7:0] corner_in  [0:4];
  logic [7:0] corner_out [0:4];
  logic [7:0] prev;

  initial begin
    stream_in  = '{8'h8b, 8'ha5, 8'hcb, 8'h42, 8'h9f, 8'h10, 8'h16, 8'hce, 8'hf3};
    stream_out = '{8'h3d, 8'h06, 8'h1f, 8'h2c, 8'hdb, 8'hca, 8'h47, 8'h8b, 8'h0d};
    corner_in  = '{8'h00, 8'hff, 8'h53, 8'h01, 8'h80};
    corner_out = '{8'h63, 8'h16, 8'hed, 8'h7c, 8'hcd};

    build_ref();

    // Reset held while the clock runs and the input is busy.
    rst_n    = 1'b0;
    in_toSub = 8'h8b;
    #1;
    check("reset_initial", out_Subed, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", out_Subed, 8'h00);
    end

    // Release: the first rising edge loads S(8b).
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", out_Subed, 8'h3d);

    // Known vectors, back to back.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_toSub = stream_in[i];
      @(posedge clk);
      #1;
      check("stream_vec", out_Subed, stream_out[i]);
      check("stream_model", out_Subed, ref_tbl[stream_in[i]]);
    end

    // Corner values.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_toSub = corner_in[i];
      @(posedge clk);
      #1;
      check("corner", out_Subed, corner_out[i]);
    end

    // Isolation: the input changes between edges, and only the value that is
    // present at the edge counts.
    prev = out_Subed;
    @(negedge clk);
    in_toSub = 8'h10;
    #2;
    check("iso_hold_a", out_Subed, prev);
    in_toSub = 8'h16;
    #1;
    check("iso_hold_b", out_Subed, prev);
    @(posedge clk);
    #1;
    check("iso_after_edge", out_Subed, 8'h47);

    // Asynchronous reset between edges while the output shows 1f.
    step(8'hcb, "pre_async");
    check("pre_async_1f", out_Subed, 8'h1f);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", out_Subed, 8'h00);
    in_toSub = 8'h42;
    @(posedge clk);
    #1;
    check("async_reset_held", out_Subed, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async_release", out_Subed, 8'h2c);

    // Exhaustive sweep, one byte per cycle.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      in_toSub = 8'(i);
      @(posedge clk);
      #1;
      check("sweep", out_Subed, ref_tbl[i]);
    end

    // Random stream. The input also changes at random between edges, and the
    // output must keep the value the previous edge loaded.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      @(negedge clk);
      prev = out_Subed;
      in_toSub = 8'($urandom_range(0, 255));
      #2;
      check("rand_hold", out_Subed, prev);
      in_toSub = v;
      @(posedge clk);
      #1;
      check("rand_vec", out_Subed, ref_tbl[v]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_aes_sbox
`default_nettype wire
